// File: rtl/load_store_unit_if.sv
// Bus bundle between the pipeline, the load/store unit and the memory addresser.
// Handshake: a request transfers on a rising edge where req_valid and req_ready
// are both high; the requester holds its fields stable while req_valid is high
// and req_ready is low, and the unit ignores the request fields while busy.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_store_data;
  logic [4:0]  memory_access_code;
  logic [31:0] memory_address;
  logic [31:0] data_to_store;
  logic [31:0] bram_read_data;
  logic        load_valid;
  logic [31:0] load_data;
  logic        store_done;
  logic        access_error;

  // Load/store unit side.
  modport slave (
    input  req_valid, req_is_store, req_funct3, req_address, req_store_data,
    input  bram_read_data,
    output req_ready, memory_access_code, memory_address, data_to_store,
    output load_valid, load_data, store_done, access_error
  );

  // Requester / memory side.
  modport master (
    output req_valid, req_is_store, req_funct3, req_address, req_store_data,
    output bram_read_data,
    input  req_ready, memory_access_code, memory_address, data_to_store,
    input  load_valid, load_data, store_done, access_error
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word requests at any alignment into one or
// two word-aligned addresser accesses and assembles/extends load results.
module load_store_unit (
  input  logic                CLOCK_50,
  input  logic                reset,
  load_store_unit_if.slave    bus,
  output logic [1:0]          fsm_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FIRST  = 2'd1;
  localparam logic [1:0] S_SECOND = 2'd2;
  localparam logic [1:0] S_WAIT   = 2'd3;

  logic [1:0]  state;
  logic        is_store_r;
  logic [2:0]  funct3_r;
  logic [31:0] addr_r;
  logic [31:0] data_r;
  logic [31:0] hold_r;
  logic        err_hold_r;  // illegal requests spend one extra cycle in WAIT

  logic [3:0]  size_mask;
  logic [7:0]  mask;
  logic        split;
  logic        legal_r;
  logic [4:0]  offset_bits;
  logic [31:0] lower_word;
  logic [31:0] lo_word;
  logic [31:0] hi_word;
  logic [31:0] shifted;
  logic [31:0] load_result;

  function automatic logic funct3_legal(input logic [2:0] f);
    return (f == 3'b000) || (f == 3'b001) || (f == 3'b010) ||
           (f == 3'b100) || (f == 3'b101);
  endfunction

  assign fsm_state     = state;
  assign bus.req_ready = (state == S_IDLE) && !reset;
  assign legal_r       = funct3_legal(funct3_r);
  assign offset_bits   = {addr_r[1:0], 3'b000};
  assign lower_word    = {addr_r[31:2], 2'b00};

  // Byte-enable mask of the access, spanning up to two words.
  always_comb begin
    size_mask = 4'b0000;
    case (funct3_r[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      2'b10:   size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
    mask  = {4'b0000, size_mask} << addr_r[1:0];
    split = |mask[7:4];
  end

  // Addresser drive: only FIRST and SECOND present an access.
  always_comb begin
    bus.memory_access_code = 5'b0_0000;
    bus.memory_address     = 32'h0;
    bus.data_to_store      = 32'h0;
    if (state == S_FIRST) begin
      bus.memory_access_code = {is_store_r, mask[3:0]};
      bus.memory_address     = lower_word;
      bus.data_to_store      = data_r << offset_bits;
    end else if (state == S_SECOND) begin
      bus.memory_access_code = {is_store_r, mask[7:4]};
      bus.memory_address     = lower_word + 32'd4;
      bus.data_to_store      = data_r >> (6'd32 - {1'b0, offset_bits});
    end
  end

  // Load assembly: the final word arrives during WAIT; a split load pairs it
  // with the first word parked in hold_r.
  always_comb begin
    lo_word     = split ? hold_r : bus.bram_read_data;
    hi_word     = split ? bus.bram_read_data : 32'h0;
    shifted     = 32'({hi_word, lo_word} >> offset_bits);
    load_result = 32'h0;
    case (funct3_r)
      3'b000:  load_result = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_result = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_result = shifted;
      3'b100:  load_result = {24'h0, shifted[7:0]};
      3'b101:  load_result = {16'h0, shifted[15:0]};
      default: load_result = 32'h0;
    endcase
  end

  // Request capture, sequencing and registered completion pulses.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state            <= S_IDLE;
      is_store_r       <= 1'b0;
      funct3_r         <= 3'b000;
      addr_r           <= 32'h0;
      data_r           <= 32'h0;
      hold_r           <= 32'h0;
      err_hold_r       <= 1'b0;
      bus.load_valid   <= 1'b0;
      bus.load_data    <= 32'h0;
      bus.store_done   <= 1'b0;
      bus.access_error <= 1'b0;
    end else begin
      bus.load_valid   <= 1'b0;
      bus.store_done   <= 1'b0;
      bus.access_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            is_store_r <= bus.req_is_store;
            funct3_r   <= bus.req_funct3;
            addr_r     <= bus.req_address;
            data_r     <= bus.req_store_data;
            err_hold_r <= !funct3_legal(bus.req_funct3);
            state      <= funct3_legal(bus.req_funct3) ? S_FIRST : S_WAIT;
          end
        end
        S_FIRST: begin
          if (split) begin
            state <= S_SECOND;
          end else if (is_store_r) begin
            state          <= S_IDLE;
            bus.store_done <= 1'b1;
          end else begin
            state <= S_WAIT;
          end
        end
        S_SECOND: begin
          hold_r <= bus.bram_read_data;
          if (is_store_r) begin
            state          <= S_IDLE;
            bus.store_done <= 1'b1;
          end else begin
            state <= S_WAIT;
          end
        end
        default: begin
          if (err_hold_r) begin
            err_hold_r <= 1'b0;
          end else begin
            state <= S_IDLE;
            if (!legal_r) begin
              bus.access_error <= 1'b1;
              if (is_store_r) begin
                bus.store_done <= 1'b1;
              end else begin
                bus.load_valid <= 1'b1;
                bus.load_data  <= 32'h0;
              end
            end else begin
              bus.load_valid <= 1'b1;
              bus.load_data  <= load_result;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table replayed cycle by cycle
// against hand-computed addresser traffic and results, plus reset and
// back-to-back sequences.
module tb_load_store_unit;

  logic        CLOCK_50;
  logic        reset;
  logic [1:0]  fsm_state;
  logic [31:0] mem_w0;
  logic [31:0] mem_w1;
  int          checks;
  int          errors;

  load_store_unit_if bus();

  load_store_unit dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus),
    .fsm_state(fsm_state)
  );

  // Clock.
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Two-word memory behind the addresser; address bit 2 picks the word.
  always @(posedge CLOCK_50) begin
    if (bus.memory_access_code[4] == 1'b0 && bus.memory_access_code[3:0] != 4'b0000)
      bus.bram_read_data <= bus.memory_address[2] ? mem_w1 : mem_w0;
    else
      bus.bram_read_data <= 32'h5A5A5A5A;
  end

  typedef struct {
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] mem0;
    logic [31:0] mem1;
    logic [4:0]  code1;
    logic [31:0] addr1;
    logic [31:0] data1;
    logic        split;
    logic [4:0]  code2;
    logic [31:0] addr2;
    logic [31:0] data2;
    int          pulse;
    logic        err;
    logic [31:0] ldata;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic drive_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d);
    bus.req_valid      = 1'b1;
    bus.req_is_store   = st;
    bus.req_funct3     = f3;
    bus.req_address    = a;
    bus.req_store_data = d;
  endtask

  // Called #1 after an edge with the unit idle; cycle k is A+k.
  task automatic run_vec(input vec_t v, input int idx);
    logic [4:0]  ec;
    logic [31:0] ea;
    logic [31:0] ed;
    mem_w0 = v.mem0;
    mem_w1 = v.mem1;
    drive_req(v.is_store, v.funct3, v.addr, v.sdata);
    tick();
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) tick();
      ec = 5'b0; ea = 32'h0; ed = 32'h0;
      if (k == 1) begin
        ec = v.code1; ea = v.addr1; ed = v.data1;
      end else if (k == 2 && v.split) begin
        ec = v.code2; ea = v.addr2; ed = v.data2;
      end
      check($sformatf("v%0d A+%0d code", idx, k), 32'(bus.memory_access_code), 32'(ec));
      check($sformatf("v%0d A+%0d addr", idx, k), bus.memory_address, ea);
      check($sformatf("v%0d A+%0d wdata", idx, k), bus.data_to_store, ed);
      check($sformatf("v%0d A+%0d load_valid", idx, k), 32'(bus.load_valid),
            32'(k == v.pulse && !v.is_store));
      check($sformatf("v%0d A+%0d store_done", idx, k), 32'(bus.store_done),
            32'(k == v.pulse && v.is_store));
      check($sformatf("v%0d A+%0d access_error", idx, k), 32'(bus.access_error),
            32'(k == v.pulse && v.err));
      check($sformatf("v%0d A+%0d req_ready", idx, k), 32'(bus.req_ready),
            32'(k >= v.pulse));
      if (k == v.pulse && !v.is_store)
        check($sformatf("v%0d load_data", idx), bus.load_data, v.ldata);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    mem_w0 = 32'h0;
    mem_w1 = 32'h0;
    bus.req_valid      = 1'b0;
    bus.req_is_store   = 1'b0;
    bus.req_funct3     = 3'b000;
    bus.req_address    = 32'h0;
    bus.req_store_data = 32'h0;

    //          st    f3      addr          sdata         mem0          mem1          code1      addr1         data1         sp    code2      addr2         data2         p  err   ldata
    vecs[0]  = '{1'b1, 3'b010, 32'h00000000, 32'hF0F1F2F3, 32'h0,        32'h0,        5'b1_1111, 32'h00000000, 32'hF0F1F2F3, 1'b0, 5'b0,      32'h0,        32'h0,        2, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 3'b010, 32'h00000000, 32'h0,        32'hF0F1F2F3, 32'h0,        5'b0_1111, 32'h00000000, 32'h0,        1'b0, 5'b0,      32'h0,        32'h0,        3, 1'b0, 32'hF0F1F2F3};
    vecs[2]  = '{1'b0, 3'b000, 32'h00000003, 32'h0,        32'hF0F1F2F3, 32'h0,        5'b0_1000, 32'h00000000, 32'h0,        1'b0, 5'b0,      32'h0,        32'h0,        3, 1'b0, 32'hFFFFFFF0};
    vecs[3]  = '{1'b0, 3'b100, 32'h00000003, 32'h0,        32'hF0F1F2F3, 32'h0,        5'b0_1000, 32'h00000000, 32'h0,        1'b0, 5'b0,      32'h0,        32'h0,        3, 1'b0, 32'h000000F0};
    vecs[4]  = '{1'b1, 3'b010, 32'h00000006, 32'h11223344, 32'h0,        32'h0,        5'b1_1100, 32'h00000004, 32'h33440000, 1'b1, 5'b1_0011, 32'h00000008, 32'h00001122, 3, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 3'b001, 32'h00000003, 32'h0,        32'hA0A1A2A3, 32'hB0B1B2B3, 5'b0_1000, 32'h00000000, 32'h0,        1'b1, 5'b0_0001, 32'h00000004, 32'h0,        4, 1'b0, 32'hFFFFB3A0};
    vecs[6]  = '{1'b0, 3'b011, 32'h00000000, 32'h0,        32'hA0A1A2A3, 32'h0,        5'b0,      32'h0,        32'h0,        1'b0, 5'b0,      32'h0,        32'h0,        3, 1'b1, 32'h0};
    vecs[7]  = '{1'b0, 3'b101, 32'h00000002, 32'h0,        32'hA0A1A2A3, 32'h0,        5'b0_1100, 32'h00000000, 32'h0,        1'b0, 5'b0,      32'h0,        32'h0,        3, 1'b0, 32'h0000A0A1};
    vecs[8]  = '{1'b0, 3'b001, 32'h00000001, 32'h0,        32'hF0F1F2F3, 32'h0,        5'b0_0110, 32'h00000000, 32'h0,        1'b0, 5'b0,      32'h0,        32'h0,        3, 1'b0, 32'hFFFFF1F2};
    vecs[9]  = '{1'b0, 3'b010, 32'hFFFFFFFD, 32'h0,        32'hA0A1A2A3, 32'hB0B1B2B3, 5'b0_1110, 32'hFFFFFFFC, 32'h0,        1'b1, 5'b0_0001, 32'h00000000, 32'h0,        4, 1'b0, 32'hA3B0B1B2};
    vecs[10] = '{1'b1, 3'b000, 32'h00000005, 32'h000000AB, 32'h0,        32'h0,        5'b1_0010, 32'h00000004, 32'h0000AB00, 1'b0, 5'b0,      32'h0,        32'h0,        2, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 3'b001, 32'h00000007, 32'h1234CDEF, 32'h0,        32'h0,        5'b1_1000, 32'h00000004, 32'hEF000000, 1'b1, 5'b1_0001, 32'h00000008, 32'h001234CD, 3, 1'b0, 32'h0};
    vecs[12] = '{1'b1, 3'b111, 32'h00000000, 32'hCAFEF00D, 32'h0,        32'h0,        5'b0,      32'h0,        32'h0,        1'b0, 5'b0,      32'h0,        32'h0,        3, 1'b1, 32'h0};
    vecs[13] = '{1'b0, 3'b001, 32'h00000000, 32'h0,        32'h12345678, 32'h0,        5'b0_0011, 32'h00000000, 32'h0,        1'b0, 5'b0,      32'h0,        32'h0,        3, 1'b0, 32'h00005678};

    // Reset state.
    tick();
    tick();
    check("reset ready low", 32'(bus.req_ready), 32'h0);
    check("reset code", 32'(bus.memory_access_code), 32'h0);
    check("reset addr", bus.memory_address, 32'h0);
    check("reset wdata", bus.data_to_store, 32'h0);
    check("reset load_valid", 32'(bus.load_valid), 32'h0);
    check("reset load_data", bus.load_data, 32'h0);
    check("reset store_done", 32'(bus.store_done), 32'h0);
    check("reset access_error", 32'(bus.access_error), 32'h0);
    reset = 1'b0;
    tick();
    check("ready after reset", 32'(bus.req_ready), 32'h1);

    // Table vectors.
    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Back-to-back: new request accepted in the load_valid cycle.
    mem_w0 = 32'h0BADF00D;
    drive_req(1'b0, 3'b010, 32'h0, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    check("b2b load_valid", 32'(bus.load_valid), 32'h1);
    check("b2b load_data", bus.load_data, 32'h0BADF00D);
    check("b2b ready in pulse", 32'(bus.req_ready), 32'h1);
    drive_req(1'b1, 3'b010, 32'h00000004, 32'h55667788);
    tick();
    bus.req_valid = 1'b0;
    check("b2b second code", 32'(bus.memory_access_code), 32'h1F);
    check("b2b second addr", bus.memory_address, 32'h00000004);
    tick();
    check("b2b store_done", 32'(bus.store_done), 32'h1);
    tick();

    // Reset during SECOND of a split load.
    mem_w0 = 32'hA0A1A2A3;
    mem_w1 = 32'hB0B1B2B3;
    drive_req(1'b0, 3'b001, 32'h00000003, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    tick();
    check("rst-mid second code", 32'(bus.memory_access_code), 32'h01);
    reset = 1'b1;
    tick();
    check("rst-mid code idle", 32'(bus.memory_access_code), 32'h0);
    check("rst-mid ready low", 32'(bus.req_ready), 32'h0);
    check("rst-mid no load_valid", 32'(bus.load_valid), 32'h0);
    reset = 1'b0;
    tick();
    check("rst-mid ready after", 32'(bus.req_ready), 32'h1);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst-mid quiet load_valid %0d", k), 32'(bus.load_valid), 32'h0);
      check($sformatf("rst-mid quiet code %0d", k), 32'(bus.memory_access_code), 32'h0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock, CLOCK_50; reset is synchronous and active-high.
REQ-002 CLOCK_50  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 req_valid  in  1  memory request present.
REQ-005 req_ready  out  1  block idle; request accepted on req_valid & req_ready at a rising edge.
REQ-006 req_is_store  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; other values illegal.
REQ-008 req_address  in  32  byte address, any alignment.
REQ-009 req_store_data  in  32  store value, right-justified.
REQ-010 memory_access_code  out  5  to addresser: bit4 write, [3:0] byte enables; 5'b0_0000 = no-op.
REQ-011 memory_address  out  32  word-aligned address to addresser.
REQ-012 data_to_store  out  32  lane-aligned write data to addresser.
REQ-013 bram_read_data  in  32  addresser writeback data, valid the cycle after a read code is presented.
REQ-014 load_valid  out  1  one-cycle pulse; load_data valid.
REQ-015 load_data  out  32  extended load result.
REQ-016 store_done  out  1  one-cycle pulse; store issued.
REQ-017 access_error  out  1  one-cycle pulse with load_valid/store_done for illegal funct3.

Function
REQ-018 Byte lane i SHALL be address 4k+i and data bits [8i+7:8i] (little-endian).
REQ-019 Request fields SHALL be registered at acceptance; inputs are ignored while busy.
REQ-020 FSM states SHALL be IDLE, FIRST, SECOND, WAIT; req_ready = 1 only in IDLE.
REQ-021 mask[7:0] SHALL be the size mask (B 0001, H 0011, W 1111) shifted left by address[1:0]; access is split when mask[7:4] != 0.
REQ-022 FIRST: address = {addr[31:2],2'b00}, code = {is_store, mask[3:0]}, data_to_store = store_data << 8*addr[1:0].
REQ-023 SECOND: address = lower word + 4 (0xFFFFFFFC wraps to 0x00000000), code = {is_store, mask[7:4]}, data_to_store = store_data >> (32 - 8*addr[1:0]).
REQ-024 IDLE and WAIT SHALL drive code 5'b0_0000, address 0, data_to_store 0.
REQ-025 Transitions: IDLE->FIRST on accept; FIRST->SECOND if split; FIRST/SECOND->WAIT if load (last access); store last access->IDLE.
REQ-026 The word read in FIRST SHALL be captured into a holding register during SECOND; WAIT captures the final word.
REQ-027 Load result SHALL be ({hi, lo} >> 8*addr[1:0]) truncated to size, sign-extended for B/H, zero-extended for BU/HU.
REQ-028 load_valid/load_data SHALL be registered: aligned load pulses cycle A+3 (A = accept cycle), split load A+4.
REQ-029 store_done SHALL pulse the cycle after the last store access: aligned A+2, split A+3.
REQ-030 Illegal funct3 SHALL issue no access (IDLE->WAIT->IDLE), then pulse access_error with load_valid (load_data 0) or store_done at A+3.
REQ-031 A new request SHALL be acceptable in the same cycle load_valid/store_done pulses.

Reset
REQ-032 On reset: state IDLE, memory_access_code 5'b0_0000, memory_address 0, data_to_store 0, load_valid 0, load_data 0, store_done 0, access_error 0, holding register 0.
REQ-033 req_ready SHALL be 0 while reset is high and 1 the first cycle after.
REQ-034 Reset mid-operation SHALL abandon the request: no pulse, no further access; an access sampled at the reset edge is not retracted.

Verification
REQ-035 SW addr 0x0 data F0F1F2F3 -> A+1: code 1_1111, address 0, data F0F1F2F3; store_done A+2.
REQ-036 LW addr 0x0, model returns F0F1F2F3 -> A+1 code 0_1111; load_valid A+3, load_data F0F1F2F3.
REQ-037 LB addr 0x3 on F0F1F2F3 -> code 0_1000, load_data FFFFFFF0; LBU -> 000000F0.
REQ-038 SW addr 0x6 data 11223344 -> A+1 addr 4 code 1_1100 data 33440000; A+2 addr 8 code 1_0011 data 00001122; store_done A+3.
REQ-039 LH addr 0x3, words A0A1A2A3 @0, B0B1B2B3 @4 -> codes 0_1000 then 0_0001; load_data FFFFB3A0 at A+4; funct3 011 -> access_error with load_valid, load_data 0.
REQ-040 Reset in SECOND of split load -> next cycle code 0_0000, no load_valid; req_ready 1 after reset deasserts.
